// File: rtl/note_envelope_shaper.sv
// Paces sine samples at the codec rate and scales them by a gate-driven ADSR envelope.
// Define ENV_EXP_RELEASE_EN for an exponential release tail instead of the linear one.
module note_envelope_shaper #(
  parameter int unsigned SAMPLE_DIV    = 1042,
  parameter logic [15:0] ATTACK_STEP   = 16'h0100,
  parameter logic [15:0] DECAY_STEP    = 16'h0040,
  parameter logic [15:0] SUSTAIN_LEVEL = 16'hC000,
  parameter logic [15:0] RELEASE_STEP  = 16'h0040,
  parameter int unsigned RELEASE_SHIFT = 8
) (
  input  logic        CLOCK_50,
  input  logic        reset,
  input  logic        gate,
  input  logic [31:0] wave_in,
  input  logic        audio_out_allowed,
  output logic        write_audio_out,
  output logic [31:0] sample_out,
  output logic [15:0] env_level,
  output logic        busy,
  output logic [15:0] overrun_count
);

  typedef enum logic [2:0] {IDLE, ATTACK, DECAY, SUSTAIN, RELEASE} state_t;

  localparam logic [15:0] TICK_LAST = 16'(SAMPLE_DIV - 1);

  state_t             state;
  logic        [15:0] tick_cnt;
  logic               tick;
  logic               pending;
  logic signed [48:0] product;
  logic               unused_product_bits;
  logic        [16:0] att_sum;
  logic        [16:0] dec_diff;
  logic        [16:0] rel_diff;
  logic        [15:0] rel_step;

  assign tick            = (tick_cnt == TICK_LAST);
  assign write_audio_out = pending & audio_out_allowed;

  assign product             = $signed(wave_in) * $signed({1'b0, env_level});
  assign unused_product_bits = ^{product[48], product[15:0]};

  // Step math carries a 17th bit so saturation and clamping are detected, never wrapped.
  assign att_sum  = {1'b0, env_level} + {1'b0, ATTACK_STEP};
  assign dec_diff = {1'b0, env_level} - {1'b0, DECAY_STEP};
  assign rel_diff = {1'b0, env_level} - {1'b0, rel_step};

`ifdef ENV_EXP_RELEASE_EN
  logic [15:0] exp_step;
  assign exp_step = env_level >> RELEASE_SHIFT;
  assign rel_step = (exp_step == 16'd0) ? 16'd1 : exp_step;
`else
  localparam int unsigned UNUSED_RELEASE_SHIFT = RELEASE_SHIFT;
  assign rel_step = RELEASE_STEP;
`endif

  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      tick_cnt      <= 16'd0;
      state         <= IDLE;
      env_level     <= 16'd0;
      sample_out    <= 32'd0;
      pending       <= 1'b0;
      busy          <= 1'b0;
      overrun_count <= 16'd0;
    end else begin
      tick_cnt <= tick ? 16'd0 : tick_cnt + 16'd1;

      // A tick always loads the newest sample; a concurrent write has already taken the old one.
      if (tick) begin
        sample_out <= product[47:16];
        pending    <= 1'b1;
        if (pending && !write_audio_out && overrun_count != 16'hFFFF)
          overrun_count <= overrun_count + 16'd1;
      end else if (write_audio_out) begin
        pending <= 1'b0;
      end

      if (tick) begin
        case (state)
          IDLE: begin
            if (gate) begin
              state <= ATTACK;
              busy  <= 1'b1;
            end
          end
          ATTACK: begin
            if (!gate) begin
              state <= RELEASE;
            end else if (att_sum >= 17'h0FFFF) begin
              env_level <= 16'hFFFF;
              state     <= DECAY;
            end else begin
              env_level <= att_sum[15:0];
            end
          end
          DECAY: begin
            if (!gate) begin
              state <= RELEASE;
            end else if (dec_diff[16] || dec_diff[15:0] <= SUSTAIN_LEVEL) begin
              env_level <= SUSTAIN_LEVEL;
              state     <= SUSTAIN;
            end else begin
              env_level <= dec_diff[15:0];
            end
          end
          SUSTAIN: begin
            if (!gate) state <= RELEASE;
          end
          RELEASE: begin
            if (gate) begin
              state <= ATTACK;
            end else if (rel_diff[16] || rel_diff[15:0] == 16'd0) begin
              env_level <= 16'd0;
              state     <= IDLE;
              busy      <= 1'b0;
            end else begin
              env_level <= rel_diff[15:0];
            end
          end
          default: begin
            state     <= IDLE;
            env_level <= 16'd0;
            busy      <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_note_envelope_shaper.sv
// Directed bench for note_envelope_shaper with a 4-cycle sample tick and coarse envelope steps.
module tb_note_envelope_shaper;

  logic        CLOCK_50 = 1'b0;
  logic        reset;
  logic        gate;
  logic [31:0] wave_in;
  logic        audio_out_allowed;
  logic        write_audio_out;
  logic [31:0] sample_out;
  logic [15:0] env_level;
  logic        busy;
  logic [15:0] overrun_count;

  int n_checks = 0;
  int n_fail   = 0;

  logic [15:0] decay_exp [4];

  always #5 CLOCK_50 = ~CLOCK_50;

  note_envelope_shaper #(
    .SAMPLE_DIV   (4),
    .ATTACK_STEP  (16'h4000),
    .DECAY_STEP   (16'h1000),
    .SUSTAIN_LEVEL(16'hC000),
    .RELEASE_STEP (16'h4000),
    .RELEASE_SHIFT(8)
  ) dut (
    .CLOCK_50         (CLOCK_50),
    .reset            (reset),
    .gate             (gate),
    .wave_in          (wave_in),
    .audio_out_allowed(audio_out_allowed),
    .write_audio_out  (write_audio_out),
    .sample_out       (sample_out),
    .env_level        (env_level),
    .busy             (busy),
    .overrun_count    (overrun_count)
  );

  task automatic applyStimulus(input int cycles);
    repeat (cycles) @(posedge CLOCK_50);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    n_checks++;
    assert (observed === expected)
    else begin
      n_fail++;
      $error("[TB] FAIL %s: observed %h expected %h", tag, observed, expected);
    end
  endtask

  initial begin
    decay_exp = '{16'hEFFF, 16'hDFFF, 16'hCFFF, 16'hC000};
    reset = 1'b1;
    gate = 1'b0;
    wave_in = 32'h4000_0000;
    audio_out_allowed = 1'b1;
    applyStimulus(2);
    checkOutput("rst_env", 32'(env_level), 32'h0);
    checkOutput("rst_sample", sample_out, 32'h0);
    checkOutput("rst_write", 32'(write_audio_out), 32'h0);
    checkOutput("rst_busy", 32'(busy), 32'h0);
    checkOutput("rst_overrun", 32'(overrun_count), 32'h0);

    reset = 1'b0;
    gate = 1'b1;
    applyStimulus(3);
    checkOutput("pre_tick_busy", 32'(busy), 32'h0);
    checkOutput("pre_tick_write", 32'(write_audio_out), 32'h0);
    applyStimulus(1);
    checkOutput("t1_busy", 32'(busy), 32'h1);
    checkOutput("t1_env", 32'(env_level), 32'h0);
    checkOutput("t1_write", 32'(write_audio_out), 32'h1);
    applyStimulus(1);
    checkOutput("t1_write_clear", 32'(write_audio_out), 32'h0);
    applyStimulus(3);
    checkOutput("t2_env", 32'(env_level), 32'h4000);
    applyStimulus(4);
    checkOutput("t3_env", 32'(env_level), 32'h8000);
    checkOutput("t3_sample", sample_out, 32'h1000_0000);
    applyStimulus(4);
    checkOutput("t4_env", 32'(env_level), 32'hC000);
    checkOutput("t4_sample", sample_out, 32'h2000_0000);
    applyStimulus(4);
    checkOutput("t5_env", 32'(env_level), 32'hFFFF);
    checkOutput("t5_sample", sample_out, 32'h3000_0000);

    for (int i = 0; i < 4; i++) begin
      applyStimulus(4);
      checkOutput($sformatf("decay_env_%0d", i), 32'(env_level), 32'(decay_exp[i]));
    end
    for (int i = 0; i < 10; i++) begin
      applyStimulus(4);
      checkOutput($sformatf("sustain_env_%0d", i), 32'(env_level), 32'hC000);
    end
    checkOutput("sustain_sample", sample_out, 32'h3000_0000);

    // Hold off the controller across three ticks, then release it.
    applyStimulus(1);
    audio_out_allowed = 1'b0;
    wave_in = 32'h0001_0000;
    applyStimulus(3);
    checkOutput("ovr1_write", 32'(write_audio_out), 32'h0);
    checkOutput("ovr1_count", 32'(overrun_count), 32'h0);
    wave_in = 32'h0002_0000;
    applyStimulus(4);
    checkOutput("ovr2_write", 32'(write_audio_out), 32'h0);
    checkOutput("ovr2_count", 32'(overrun_count), 32'h1);
    wave_in = 32'h0003_0000;
    applyStimulus(4);
    checkOutput("ovr3_write", 32'(write_audio_out), 32'h0);
    checkOutput("ovr3_count", 32'(overrun_count), 32'h2);
    checkOutput("ovr3_sample", sample_out, 32'h0002_4000);
    audio_out_allowed = 1'b1;
    #1;
    checkOutput("drain_write", 32'(write_audio_out), 32'h1);
    applyStimulus(1);
    checkOutput("drain_clear", 32'(write_audio_out), 32'h0);
    checkOutput("drain_count", 32'(overrun_count), 32'h2);

    gate = 1'b0;
    wave_in = 32'h4000_0000;
    applyStimulus(3);
    checkOutput("r0_env", 32'(env_level), 32'hC000);
    checkOutput("r0_busy", 32'(busy), 32'h1);
    applyStimulus(4);
    checkOutput("r1_env", 32'(env_level), 32'h8000);
    wave_in = 32'hC000_0000;
    applyStimulus(4);
    checkOutput("r2_env", 32'(env_level), 32'h4000);
    checkOutput("r2_sample_neg", sample_out, 32'hE000_0000);
    applyStimulus(4);
    checkOutput("r3_env", 32'(env_level), 32'h0);
    checkOutput("r3_busy", 32'(busy), 32'h0);
    applyStimulus(4);
    checkOutput("idle_env", 32'(env_level), 32'h0);
    checkOutput("idle_busy", 32'(busy), 32'h0);

    gate = 1'b1;
    applyStimulus(4);
    checkOutput("rt_attack_busy", 32'(busy), 32'h1);
    checkOutput("rt_attack_env", 32'(env_level), 32'h0);
    applyStimulus(4);
    checkOutput("rt_attack_env2", 32'(env_level), 32'h4000);
    gate = 1'b0;
    applyStimulus(4);
    checkOutput("rt_release_env", 32'(env_level), 32'h4000);
    gate = 1'b1;
    applyStimulus(4);
    checkOutput("rt_retrig_env", 32'(env_level), 32'h4000);
    checkOutput("rt_retrig_busy", 32'(busy), 32'h1);
    applyStimulus(4);
    checkOutput("rt_next_env", 32'(env_level), 32'h8000);

    reset = 1'b1;
    applyStimulus(1);
    checkOutput("mid_rst_env", 32'(env_level), 32'h0);
    checkOutput("mid_rst_sample", sample_out, 32'h0);
    checkOutput("mid_rst_write", 32'(write_audio_out), 32'h0);
    checkOutput("mid_rst_busy", 32'(busy), 32'h0);
    checkOutput("mid_rst_overrun", 32'(overrun_count), 32'h0);
    reset = 1'b0;
    applyStimulus(1);
    checkOutput("post_rst_write", 32'(write_audio_out), 32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
